mem_bist_ctrl: RTL

Parametrised hardware built-in self-test engine for the single-port synchronous memory block. It replaces bench-driven clear and data=address checks with an on-chip sequencer. It drives the memory's address, write and read strobes, compares read data against the expected pattern and reports pass/fail, an error count and the first failing address. Four modes are supported: clear, data=address, checkerboard and a three-phase march.

---
 rtl/mem_bist_ctrl_if.sv | 33 +++
 rtl/mem_bist_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/mem_bist_ctrl_if.sv
// Control/status and memory-port bundle for mem_bist_ctrl.
// master = BIST engine side, slave = environment (host + memory) side.
interface mem_bist_ctrl_if #(
    parameter int ADDR_WIDTH    = 5,
    parameter int DATA_WIDTH    = 8,
    parameter int ERR_CNT_WIDTH = 16
) ();
    logic                     start;
    logic [1:0]               mode;
    logic                     busy;
    logic                     done;
    logic                     pass;
    logic [ERR_CNT_WIDTH-1:0] err_count;
    logic                     first_err_valid;
    logic [ADDR_WIDTH-1:0]    first_err_addr;
    logic [ADDR_WIDTH-1:0]    mem_addr;
    logic                     mem_wr_en;
    logic                     mem_rd_en;
    logic [DATA_WIDTH-1:0]    mem_wdata;
    logic [DATA_WIDTH-1:0]    mem_rdata;

    modport master (
        input  start, mode, mem_rdata,
        output busy, done, pass, err_count, first_err_valid, first_err_addr,
               mem_addr, mem_wr_en, mem_rd_en, mem_wdata
    );

    modport slave (
        output start, mode, mem_rdata,
        input  busy, done, pass, err_count, first_err_valid, first_err_addr,
               mem_addr, mem_wr_en, mem_rd_en, mem_wdata
    );
endinterface

// File: rtl/mem_bist_ctrl.sv
// Memory BIST sequencer: clear, data=address, checkerboard and 3-phase march
// over a single-port synchronous RAM with one-cycle read latency.
module mem_bist_ctrl #(
    parameter int ADDR_WIDTH    = 5,
    parameter int DATA_WIDTH    = 8,
    parameter int ERR_CNT_WIDTH = 16
) (
    input logic             clk,
    input logic             rst_n,
    mem_bist_ctrl_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_CMP, S_FIN} state_t;
    typedef enum logic [1:0] {PH_A, PH_B, PH_C} phase_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

    state_t                   state_q, state_d;
    phase_t                   phase_q, phase_d;
    logic [1:0]               mode_q, mode_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
    logic                     fev_q, fev_d;
    logic [ADDR_WIDTH-1:0]    fea_q, fea_d;
    logic                     pass_q, pass_d;

    logic [DATA_WIDTH+ADDR_WIDTH-1:0] addr_ext;
    logic [DATA_WIDTH-1:0]            chk_pat, exp_data, wr_data;
    logic                             mismatch;

    // Expected read data doubles as write data except in the march, where
    // phase B writes the inverse of what it checks.
    always_comb begin
        addr_ext = {{DATA_WIDTH{1'b0}}, addr_q};
        chk_pat  = '0;
        for (int i = 0; i < DATA_WIDTH; i++) chk_pat[i] = addr_q[0] ^ (i % 2 == 0);
        case (mode_q)
            2'd0:    exp_data = '0;
            2'd1:    exp_data = addr_ext[DATA_WIDTH-1:0];
            2'd2:    exp_data = chk_pat;
            default: exp_data = (phase_q == PH_C) ? {DATA_WIDTH{1'b1}} : '0;
        endcase
        if (mode_q == 2'd3) wr_data = (phase_q == PH_B) ? {DATA_WIDTH{1'b1}} : '0;
        else                wr_data = exp_data;
    end

    assign mismatch = (state_q == S_CMP) && (bus.mem_rdata != exp_data);

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        mode_d    = mode_q;
        addr_d    = addr_q;
        err_cnt_d = err_cnt_q;
        fev_d     = fev_q;
        fea_d     = fea_q;
        pass_d    = pass_q;
        case (state_q)
            S_IDLE: if (bus.start) begin
                mode_d    = bus.mode;
                addr_d    = '0;
                phase_d   = PH_A;
                err_cnt_d = '0;
                fev_d     = 1'b0;
                fea_d     = '0;
                pass_d    = 1'b0;
                state_d   = S_WR;
            end
            S_WR: begin
                if (mode_q != 2'd3) begin
                    state_d = S_RD;
                end else if (phase_q == PH_A) begin
                    if (addr_q == ADDR_MAX) begin
                        phase_d = PH_B;
                        addr_d  = '0;
                        state_d = S_RD;
                    end else begin
                        addr_d  = addr_q + ADDR_WIDTH'(1);
                    end
                end else begin
                    // Phase B hands over to the descending phase C at the top address.
                    state_d = S_RD;
                    if (addr_q == ADDR_MAX) phase_d = PH_C;
                    else                    addr_d  = addr_q + ADDR_WIDTH'(1);
                end
            end
            S_RD: state_d = S_CMP;
            S_CMP: begin
                if (mismatch) begin
                    if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
                    if (!fev_q) begin
                        fev_d = 1'b1;
                        fea_d = addr_q;
                    end
                end
                if (mode_q == 2'd3) begin
                    if (phase_q == PH_B)   state_d = S_WR;
                    else if (addr_q == '0) state_d = S_FIN;
                    else begin
                        addr_d  = addr_q - ADDR_WIDTH'(1);
                        state_d = S_RD;
                    end
                end else if (addr_q == ADDR_MAX) begin
                    state_d = S_FIN;
                end else begin
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    state_d = S_WR;
                end
                if (state_d == S_FIN) pass_d = (err_cnt_d == '0);
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            phase_q   <= PH_A;
            mode_q    <= 2'd0;
            addr_q    <= '0;
            err_cnt_q <= '0;
            fev_q     <= 1'b0;
            fea_q     <= '0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            mode_q    <= mode_d;
            addr_q    <= addr_d;
            err_cnt_q <= err_cnt_d;
            fev_q     <= fev_d;
            fea_q     <= fea_d;
            pass_q    <= pass_d;
        end
    end

    assign bus.busy            = (state_q == S_WR) || (state_q == S_RD) || (state_q == S_CMP);
    assign bus.done            = (state_q == S_FIN);
    assign bus.pass            = pass_q;
    assign bus.err_count       = err_cnt_q;
    assign bus.first_err_valid = fev_q;
    assign bus.first_err_addr  = fea_q;
    assign bus.mem_addr        = addr_q;
    assign bus.mem_wr_en       = (state_q == S_WR);
    assign bus.mem_rd_en       = (state_q == S_RD);
    assign bus.mem_wdata       = (state_q == S_WR) ? wr_data : '0;
endmodule
